apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB3 completer that sits directly downstream of the team's APB requester and terminates its SETUP/ACCESS transfers. It exposes a bank of 32-bit read/write registers. It inserts a parameterised number of wait states via PREADY and flags bad accesses with PSLVERR. It is the standard peripheral-side endpoint for bring-up and regression of the APB path.

## Interface
Parameters:
- DEPTH, 16: number of 32-bit registers; power of two, 2..256.
- WAIT_CYCLES, 0: wait states inserted in ACCESS before PREADY; 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of register 0; aligned to DEPTH*4.

Ports (reset PRESET, asynchronous, active-low; clock PCLK):
- PCLK, input, 1: APB clock; all state updates on rising edge.
- PRESET, input, 1: asynchronous active-low reset.
- PSEL, input, 1: completer select.
- PENABLE, input, 1: ACCESS-phase indicator.
- PWRITE, input, 1: 1 = write, 0 = read.
- PADDR, input, 32: byte address.
- PWDATA, input, 32: write data.
- PSTRB, input, 4: byte write strobes; used only with APB_SLAVE_PSTRB_EN.
- PRDATA, output, 32: read data; valid when PREADY=1 on a read.
- PREADY, output, 1: transfer completion.
- PSLVERR, output, 1: error response; meaningful only when PREADY=1.

## Operation
- FSM states: IDLE, ACCESS (2-bit encoding, one spare state that decodes to IDLE).
- IDLE: when PSEL=1 and PENABLE=0 (SETUP phase):
  - latch PADDR, PWRITE, PWDATA and PSTRB;
  - compute err = (PADDR[1:0]!=0) or (PADDR - BASE_ADDR) >= DEPTH*4, using a 32-bit unsigned subtract so an address below the base wraps and fails;
  - load wait counter = WAIT_CYCLES;
  - load PRDATA = err ? 0 : reg[index], where index = (PADDR-BASE_ADDR)[log2(DEPTH)+1:2];
  - go to ACCESS.
- ACCESS:
  - PREADY = (cnt==0), combinational from state and counter; the counter decrements each cycle while nonzero.
  - On the edge with PSEL&PENABLE&PREADY: if the latched write is set and err=0, update reg[index] with the latched data, then go to IDLE.
  - A read with err=1 returns PRDATA=0.
  - A write with err=1 updates nothing.
- PSLVERR = PREADY & err_latched; it is 0 at all other times.
- Protocol violation: if PSEL=0 in ACCESS, abort to IDLE with no register update and no PREADY.
- Back-to-back: a new SETUP in the cycle after completion is accepted normally. There is no idle cycle requirement.
- Registers have no read side effects. PRDATA holds its value between transfers.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, all registers 0, FSM=IDLE, counter=0.
- Reset mid-transfer: the transfer is dropped and no write occurs.
- Transfer length is 2+WAIT_CYCLES cycles (SETUP, then 1+WAIT_CYCLES ACCESS cycles).
- With WAIT_CYCLES=0, PREADY is high in the first ACCESS cycle.
- Write data is visible to a read whose SETUP phase is in the cycle after the write completes.
- PREADY is never high in IDLE. PREADY is high for exactly one cycle per completed transfer.

## Configuration
- APB_SLAVE_PSTRB_EN defined: on a write, byte lane n is updated only when PSTRB[n]=1. PSTRB=0 performs no update and reports no error.
- APB_SLAVE_PSTRB_EN undefined: PSTRB is ignored and every error-free write updates all 32 bits.

## Test plan
- Reset, then write 0xDEADBEEF to BASE+0x8 and read it back -> PRDATA=0xDEADBEEF, PSLVERR=0, each transfer 2 cycles.
- WAIT_CYCLES=3: read BASE+0x4 -> PREADY low for 3 ACCESS cycles and high on the 4th; transfer is 5 cycles total.
- Write to BASE+0x40 (DEPTH=16) and to BASE+0x2 -> PSLVERR=1 with PREADY; reading back BASE+0x0 returns its previous value; the error read returns 0.
- PSTRB_EN: register holds 0x11223344, write 0xAABBCCDD with PSTRB=4'b0101 -> reads 0x11BB33DD. Without the macro -> reads 0xAABBCCDD.
- Drop PSEL mid-ACCESS on a write with WAIT_CYCLES=2 -> no PREADY, register unchanged, next transfer completes normally.
- Assert PRESET low during ACCESS of a write -> outputs return to 0 immediately and the register stays 0.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer exposing DEPTH 32-bit read/write registers.
// Inserts WAIT_CYCLES wait states before PREADY and reports misaligned or
// out-of-range accesses through PSLVERR.
// Optional feature macro: APB_SLAVE_PSTRB_EN enables byte-lane write strobes
// (PSTRB); without it every error-free write updates all 32 bits.
module apb_slave_regfile #(
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]      regs [DEPTH];
    logic [IDX_W-1:0] idx_q;
    logic             err_q;
    logic             write_q;
    logic [31:0]      wdata_q;
    logic [3:0]       cnt_q;
    logic [31:0]      prdata_q;
    logic [31:0]      merged;

    logic [31:0]      offset;
    logic             setup_err;
    logic [IDX_W-1:0] setup_idx;
    logic             is_access;
    logic             setup;
    logic             complete;

`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0]       strb_q;
`else
    logic             unused_pstrb;
    assign unused_pstrb = ^PSTRB;
`endif

    // Unsigned subtract: addresses below the base wrap to a huge offset and fail the range test
    assign offset    = PADDR - BASE_ADDR;
    assign setup_err = (PADDR[1:0] != 2'b00) || (offset >= SPAN);
    assign setup_idx = offset[IDX_W+1:2];
    assign is_access = (state_q == ACCESS);
    assign setup     = !is_access && PSEL && !PENABLE;
    assign complete  = PREADY && PENABLE;

    // State register
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the spare encoding falls into the IDLE branch
    always_comb begin
        state_d = IDLE;
        case (state_q)
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (complete) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Output decode: PREADY only in ACCESS with PSEL held and wait states exhausted
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        if (is_access && PSEL && (cnt_q == 4'd0)) begin
            PREADY  = 1'b1;
            PSLVERR = err_q;
        end
    end

    assign PRDATA = prdata_q;

    // Write-data merge with the current register contents
    always_comb begin
        merged = wdata_q;
`ifdef APB_SLAVE_PSTRB_EN
        merged = regs[idx_q];
        for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
`endif
    end

    // Transfer capture at SETUP, wait-state countdown, and register write at completion
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            idx_q    <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            prdata_q <= '0;
`ifdef APB_SLAVE_PSTRB_EN
            strb_q   <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (setup) begin
                idx_q    <= setup_idx;
                err_q    <= setup_err;
                write_q  <= PWRITE;
                wdata_q  <= PWDATA;
                cnt_q    <= 4'(WAIT_CYCLES);
                prdata_q <= setup_err ? 32'h0 : regs[setup_idx];
`ifdef APB_SLAVE_PSTRB_EN
                strb_q   <= PSTRB;
`endif
            end else if (is_access && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (complete && write_q && !err_q) begin
                regs[idx_q] <= merged;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed bench for apb_slave_regfile.
// Instance A: base 0, no wait states. Instance B: offset base, 3 wait states.
// Expected values for the strobe test follow APB_SLAVE_PSTRB_EN.
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE_B = 32'h4000_0100;

    logic        PCLK;
    logic        PRESET;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        psel_a, psel_b;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b;
    logic        pslverr_a, pslverr_b;

    int check_count = 0;
    int error_count = 0;

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_a (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
    );

    apb_slave_regfile #(.DEPTH(16), .WAIT_CYCLES(3), .BASE_ADDR(BASE_B)) dut_b (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
    );

    // Free-running clock
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One full SETUP/ACCESS transfer on instance sel (0=A, 1=B), starting in the current cycle
    task automatic applyStimulus(input int sel, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 output logic [31:0] rdata, output logic err,
                                 output int cycles);
        psel_a  = (sel == 0);
        psel_b  = (sel == 1);
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        PSTRB   = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cycles  = 2;
        while (!(sel == 0 ? pready_a : pready_b) && cycles < 40) begin
            @(posedge PCLK); #1;
            cycles++;
        end
        if (!(sel == 0 ? pready_a : pready_b)) begin
            checkOutput("pready_timeout", 32'd0, 32'd1);
        end
        rdata = (sel == 0) ? prdata_a : prdata_b;
        err   = (sel == 0) ? pslverr_a : pslverr_b;
        @(posedge PCLK); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic runTransfer(input string tag, input int sel, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_cycles);
        logic [31:0] rd;
        logic        er;
        int          cy;
        applyStimulus(sel, wr, addr, data, strb, rd, er, cy);
        if (!wr) checkOutput({tag, "_rdata"}, rd, exp_rdata);
        checkOutput({tag, "_pslverr"}, 32'(er), 32'(exp_err));
        checkOutput({tag, "_cycles"}, 32'(cy), 32'(exp_cycles));
        checkOutput({tag, "_idle_pready"}, 32'(sel == 0 ? pready_a : pready_b), 32'd0);
        checkOutput({tag, "_idle_pslverr"}, 32'(sel == 0 ? pslverr_a : pslverr_b), 32'd0);
    endtask

    localparam logic [31:0] STRB_EXP =
`ifdef APB_SLAVE_PSTRB_EN
        32'h11BB_33DD;
`else
        32'hAABB_CCDD;
`endif
    localparam logic [31:0] STRB0_EXP =
`ifdef APB_SLAVE_PSTRB_EN
        32'h11BB_33DD;
`else
        32'h9999_9999;
`endif

    // Directed sequence
    initial begin
        PRESET  = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;

        $display("[TB] reset state");
        checkOutput("rst_prdata_a", prdata_a, 32'h0);
        checkOutput("rst_pready_a", 32'(pready_a), 32'h0);
        checkOutput("rst_pslverr_a", 32'(pslverr_a), 32'h0);
        checkOutput("rst_prdata_b", prdata_b, 32'h0);
        checkOutput("rst_pready_b", 32'(pready_b), 32'h0);

        $display("[TB] basic write/read, zero wait states, back-to-back");
        runTransfer("a_wr8", 0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 2);
        runTransfer("a_rd8", 0, 1'b0, 32'h8, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 2);
        runTransfer("a_wr0", 0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 2);
        runTransfer("a_rd3c", 0, 1'b0, 32'h3C, 32'h0, 4'hF, 32'h0, 1'b0, 2);

        $display("[TB] error accesses");
        runTransfer("a_wr40", 0, 1'b1, 32'h40, 32'hBAD0_BAD0, 4'hF, 32'h0, 1'b1, 2);
        runTransfer("a_wr2", 0, 1'b1, 32'h2, 32'hBAD1_BAD1, 4'hF, 32'h0, 1'b1, 2);
        runTransfer("a_rd0", 0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 2);
        runTransfer("a_rd40", 0, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b1, 2);
        runTransfer("a_rd8b", 0, 1'b0, 32'h8, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 2);

        $display("[TB] byte strobes");
        runTransfer("a_wr4", 0, 1'b1, 32'h4, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 2);
        runTransfer("a_wr4s", 0, 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 2);
        runTransfer("a_rd4s", 0, 1'b0, 32'h4, 32'h0, 4'hF, STRB_EXP, 1'b0, 2);
        runTransfer("a_wr4z", 0, 1'b1, 32'h4, 32'h9999_9999, 4'b0000, 32'h0, 1'b0, 2);
        runTransfer("a_rd4z", 0, 1'b0, 32'h4, 32'h0, 4'hF, STRB0_EXP, 1'b0, 2);

        $display("[TB] wait states and offset base");
        runTransfer("b_wr4", 1, 1'b1, BASE_B + 32'h4, 32'h5555_AAAA, 4'hF, 32'h0, 1'b0, 5);
        runTransfer("b_rd4", 1, 1'b0, BASE_B + 32'h4, 32'h0, 4'hF, 32'h5555_AAAA, 1'b0, 5);
        runTransfer("b_rd_below", 1, 1'b0, BASE_B - 32'h4, 32'h0, 4'hF, 32'h0, 1'b1, 5);
        runTransfer("b_rd3c", 1, 1'b0, BASE_B + 32'h3C, 32'h0, 4'hF, 32'h0, 1'b0, 5);
        runTransfer("b_rd40", 1, 1'b0, BASE_B + 32'h40, 32'h0, 4'hF, 32'h0, 1'b1, 5);

        $display("[TB] PSEL dropped during ACCESS");
        psel_b  = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = BASE_B + 32'h4;
        PWDATA  = 32'hFFFF_FFFF;
        PSTRB   = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        checkOutput("abort_wait_pready", 32'(pready_b), 32'h0);
        @(posedge PCLK); #1;
        psel_b  = 1'b0;
        PENABLE = 1'b0;
        checkOutput("abort_drop_pready", 32'(pready_b), 32'h0);
        @(posedge PCLK); #1;
        checkOutput("abort_idle_pready", 32'(pready_b), 32'h0);
        runTransfer("b_rd4_abort", 1, 1'b0, BASE_B + 32'h4, 32'h0, 4'hF, 32'h5555_AAAA, 1'b0, 5);

        $display("[TB] reset during ACCESS");
        psel_b  = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = BASE_B + 32'h8;
        PWDATA  = 32'h0000_0077;
        PSTRB   = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PRESET  = 1'b0;
        #1;
        checkOutput("mid_rst_prdata", prdata_b, 32'h0);
        checkOutput("mid_rst_pready", 32'(pready_b), 32'h0);
        checkOutput("mid_rst_pslverr", 32'(pslverr_b), 32'h0);
        @(posedge PCLK); #1;
        PRESET  = 1'b1;
        psel_b  = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        runTransfer("b_rd8_rst", 1, 1'b0, BASE_B + 32'h8, 32'h0, 4'hF, 32'h0, 1'b0, 5);
        runTransfer("b_rd4_rst", 1, 1'b0, BASE_B + 32'h4, 32'h0, 4'hF, 32'h0, 1'b0, 5);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
